ex_result_stage: RTL
====================

Name: ex_result_stage

Overview:
- Execute-stage result buffer directly downstream of the MIPS ALU.
- Captures the ALU result and flags {z,c,n,o} together with the destination register and write enable.
- Detects signed overflow on ADD/SUB, suppresses the register-file write for that instruction and raises an overflow exception.
- Presents results to the MEM stage through a small valid/ready FIFO, so MEM back-pressure does not force a combinational stall onto the ALU.

Parameters:
- W, 32: datapath width of the ALU result.
- DEPTH, 2: number of buffer entries; power of two, at least 2.
- CNT_W, 8: width of the overflow-exception counter.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  ALU operation valid this cycle.
- in_ready  out  1  buffer can accept; equals (count != DEPTH).
- alu_r  in  W  ALU result r.
- alu_z, alu_c, alu_n, alu_o  in  1 each  ALU flags.
- alu_op  in  4  aluc code of the operation (0010=ADD, 0011=SUB).
- in_rd  in  5  destination register index.
- in_we  in  1  register-file write request.
- flush  in  1  synchronous pipeline flush.
- clr_sticky  in  1  clears the sticky flags.
- out_valid  out  1  head entry valid.
- out_ready  in  1  MEM stage accepts the head.
- out_r  out  W  head result.
- out_rd  out  5  head destination.
- out_we  out  1  head write enable, already overflow-masked.
- out_flags  out  4  head {z,c,n,o}.
- exc_ovf  out  1  one-cycle overflow exception pulse.
- exc_rd  out  5  rd of the faulting instruction; held until the next exception.
- sticky  out  4  OR-accumulated {z,c,n,o} since the last clear.
- exc_cnt  out  CNT_W  saturating overflow count.

Behaviour:
- Reset (async, rst_n=0): count=0, rd/wr pointers=0, out_valid=0, exc_ovf=0, exc_rd=0, sticky=0, exc_cnt=0. Datapath outputs read 0 while empty.
- Push: push = in_valid && in_ready && !flush.
  - Entry stored: {alu_r, alu_op-derived we, in_rd, flags}.
  - Stored we = in_we && !ovf, where ovf = alu_o && (alu_op==4'b0010 || alu_op==4'b0011).
  - alu_o for any other aluc is ignored: no exception, and we is not masked.
- Pop: pop = out_valid && out_ready && !flush. The head advances.
- Count: count_next = count + push - pop.
  - Push and pop in the same cycle at count=1 leaves count=1, and the new entry becomes the head next cycle.
  - At count=DEPTH, in_ready=0 and no push can occur.
  - Pointers wrap modulo DEPTH.
- Latency: an entry pushed in cycle N is visible on out_* in cycle N+1 when the buffer was empty. out_* are driven from registered storage only, with no combinational path from alu_* to out_*.
- Flow control: in_ready depends only on count, never on out_ready. out_* hold stable while out_valid=1 and out_ready=0.
- Exception: on a push with ovf, in cycle N+1:
  - exc_ovf=1 for exactly one cycle;
  - exc_rd=in_rd;
  - exc_cnt increments, saturating at 2^CNT_W-1.
  - Back-to-back overflow pushes produce back-to-back pulses.
- Sticky: on each push, sticky |= {alu_z, alu_c, alu_n, alu_o}.
  - clr_sticky sets sticky=0.
  - If clr_sticky coincides with a push, the push's flags are kept after the clear: sticky = new flags.
- Flush:
  - Next cycle: count=0, pointers=0, out_valid=0.
  - An instruction presented in the flush cycle is dropped: no exception, no sticky or counter update.
  - An exc_ovf pulse already scheduled from the previous cycle still fires.
- Reset mid-operation: all state clears immediately; any in-flight pulse is lost.

Decomposition:
- Shared package (mips_pkg):
  - ALUC_ADD=4'b0010, ALUC_SUB=4'b0011, plus the other aluc codes;
  - flag bit indices Z=3, C=2, N=1, O=0;
  - REG_IDX_W=5.
- Sub-module result_fifo: parameterised DEPTH×(W+10) storage with pointers and count, exposing push/pop/full/empty.
- Overflow detection, sticky flags and counter stay in the top level.

Test Plan:
- ADD overflow: alu_op=0010, alu_r=32'h80000000, alu_o=1, in_rd=5, in_we=1, out_ready=1 → next cycle out_r=32'h80000000, out_we=0, out_flags=4'b0011, exc_ovf=1, exc_rd=5, exc_cnt=1.
- Non-arithmetic o ignored: alu_op=0000 (ADDU), alu_o=1, in_we=1 → out_we=1, exc_ovf=0, exc_cnt unchanged.
- Back-pressure: out_ready=0, push 3 results (1,2,3) → in_ready=0 after 2 accepted, third held by source. Then out_ready=1 → outputs 1,2,3 in order with no loss or duplication.
- Simultaneous push/pop at count=1 → count stays 1, FIFO order preserved, in_ready stays 1.
- Flush with in_valid=1, ovf=1, two entries buffered → next cycle out_valid=0, count=0, exc_ovf=0, exc_cnt unchanged.
- Saturation and sticky: 256 overflowing SUBs with CNT_W=8 → exc_cnt=255. Then clr_sticky together with a push of flags 4'b1000 → sticky=4'b1000.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS execute-stage definitions: aluc codes, flag layout, result metadata.
package mips_pkg;

  localparam int REG_IDX_W = 5;
  localparam int FLAG_W    = 4;

  // Flag bit positions inside a {z,c,n,o} vector
  localparam int FLAG_Z = 3;
  localparam int FLAG_C = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_O = 0;

  typedef enum logic [3:0] {
    ALUC_ADDU = 4'b0000,
    ALUC_SUBU = 4'b0001,
    ALUC_ADD  = 4'b0010,
    ALUC_SUB  = 4'b0011,
    ALUC_AND  = 4'b0100,
    ALUC_OR   = 4'b0101,
    ALUC_XOR  = 4'b0110,
    ALUC_NOR  = 4'b0111,
    ALUC_LUI  = 4'b1000,
    ALUC_SLT  = 4'b1010,
    ALUC_SLTU = 4'b1011,
    ALUC_SRA  = 4'b1100,
    ALUC_SRL  = 4'b1101,
    ALUC_SLL  = 4'b1110
  } aluc_e;

  // Everything stored alongside the result word
  typedef struct packed {
    logic                 we;
    logic [REG_IDX_W-1:0] rd;
    logic [FLAG_W-1:0]    flags;
  } res_meta_t;

  localparam int META_W = $bits(res_meta_t);

  // Only the trapping arithmetic ops turn the o flag into an exception
  function automatic logic arith_ovf(input logic [3:0] op, input logic o);
    return o && (op == ALUC_ADD || op == ALUC_SUB);
  endfunction

endpackage

// File: rtl/result_fifo.sv
// Small circular buffer between the ALU and MEM; output is driven from storage only.
module result_fifo
  import mips_pkg::*;
#(
  parameter int WD    = 42,
  parameter int DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [WD-1:0] din,
  output logic [WD-1:0] dout,
  output logic          full,
  output logic          empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WD-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   cnt;

  assign full  = (cnt == (AW+1)'(DEPTH));
  assign empty = (cnt == '0);
  // Empty buffer reads as zero so stale data never leaks downstream
  assign dout  = empty ? '0 : mem[rd_ptr];

  // Storage write; contents need no reset since empty masks them
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= din;
  end

  // Pointer and occupancy tracking; flush wins over push/pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/ex_result_stage.sv
// Execute-stage result buffer: overflow trap, sticky flags, exception counter, MEM-side FIFO.
module ex_result_stage
  import mips_pkg::*;
#(
  parameter int W     = 32,
  parameter int DEPTH = 2,
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [W-1:0]         alu_r,
  input  logic                 alu_z,
  input  logic                 alu_c,
  input  logic                 alu_n,
  input  logic                 alu_o,
  input  logic [3:0]           alu_op,
  input  logic [REG_IDX_W-1:0] in_rd,
  input  logic                 in_we,
  input  logic                 flush,
  input  logic                 clr_sticky,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [W-1:0]         out_r,
  output logic [REG_IDX_W-1:0] out_rd,
  output logic                 out_we,
  output logic [FLAG_W-1:0]    out_flags,
  output logic                 exc_ovf,
  output logic [REG_IDX_W-1:0] exc_rd,
  output logic [FLAG_W-1:0]    sticky,
  output logic [CNT_W-1:0]     exc_cnt
);

  localparam int WD = W + META_W;

  logic              push, pop, ovf, full, empty;
  logic [FLAG_W-1:0] flags;
  res_meta_t         meta_in, meta_out;
  logic [WD-1:0]     din, dout;

  assign flags    = {alu_z, alu_c, alu_n, alu_o};
  assign ovf      = arith_ovf(alu_op, alu_o);
  assign in_ready = !full;
  assign out_valid = !empty;
  assign push     = in_valid && in_ready && !flush;
  assign pop      = out_valid && out_ready && !flush;

  assign meta_in.we    = in_we && !ovf;
  assign meta_in.rd    = in_rd;
  assign meta_in.flags = flags;
  assign din           = {alu_r, meta_in};

  result_fifo #(.WD(WD), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .din   (din),
    .dout  (dout),
    .full  (full),
    .empty (empty)
  );

  assign out_r     = dout[WD-1:META_W];
  assign meta_out  = dout[META_W-1:0];
  assign out_rd    = meta_out.rd;
  assign out_we    = meta_out.we;
  assign out_flags = meta_out.flags;

  // Overflow trap: one-cycle pulse, latched rd, saturating count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exc_ovf <= 1'b0;
      exc_rd  <= '0;
      exc_cnt <= '0;
    end else begin
      exc_ovf <= push && ovf;
      if (push && ovf) begin
        exc_rd <= in_rd;
        if (exc_cnt != '1) exc_cnt <= exc_cnt + CNT_W'(1);
      end
    end
  end

  // Sticky flags; a push coinciding with a clear survives the clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          sticky <= '0;
    else if (clr_sticky) sticky <= push ? flags : '0;
    else if (push)       sticky <= sticky | flags;
  end

endmodule
